// File: rtl/ddr3_dqsw_wrlvl_pkg.sv
// rtl/ddr3_dqsw_wrlvl_pkg.sv - shared types, counter widths and sample-bit helper for DQSW write leveling
//
// Contents:
//   wrlvl_state_e  : controller FSM states
//   SETTLE_CNT_W   : settle counter width (SETTLE_CYCLES up to 2**SETTLE_CNT_W)
//   VOTE_CNT_W     : vote / sample-window counter width (VOTE_SAMPLES up to 15)
//   sample_bit()   : reduces the two RX_DATA feedback bits to one training bit

package ddr3_dqsw_wrlvl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CLEAR,
        S_SAMPLE,
        S_EVAL,
        S_MOVE,
        S_DONE,
        S_FAIL
    } wrlvl_state_e;

    localparam int SETTLE_CNT_W = 8;
    localparam int VOTE_CNT_W   = 4;

    // Both DQ feedback bits must agree on 1; a split capture is treated as 0
    // so that a marginal sample never counts as the 0->1 transition.
    function automatic logic sample_bit(input logic [1:0] rx_data);
        return rx_data[1] & rx_data[0];
    endfunction

endpackage

// File: rtl/ddr3_dqsw_wrlvl_ctrl_if.sv
// rtl/ddr3_dqsw_wrlvl_ctrl_if.sv - controller to DQSW training IOD signal bundle
//
// Signals:
//   RX_DATA                  IOD -> ctrl  DQ feedback (RX_DATA_0)
//   EYE_MONITOR_EARLY/LATE   IOD -> ctrl  eye-monitor flags
//   DELAY_LINE_OUT_OF_RANGE  IOD -> ctrl  delay-line limit flag
//   DELAY_LINE_MOVE          ctrl -> IOD  one tap step pulse
//   DELAY_LINE_DIRECTION     ctrl -> IOD  1 = increment
//   DELAY_LINE_LOAD          ctrl -> IOD  reload static delay pulse
//   EYE_MONITOR_CLEAR_FLAGS  ctrl -> IOD  clear eye flags pulse
// Modports: master = controller side, slave = IOD side.

interface ddr3_dqsw_wrlvl_ctrl_if;

    logic [1:0] RX_DATA;
    logic       EYE_MONITOR_EARLY;
    logic       EYE_MONITOR_LATE;
    logic       DELAY_LINE_OUT_OF_RANGE;
    logic       DELAY_LINE_MOVE;
    logic       DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_LOAD;
    logic       EYE_MONITOR_CLEAR_FLAGS;

    modport master (
        input  RX_DATA,
        input  EYE_MONITOR_EARLY,
        input  EYE_MONITOR_LATE,
        input  DELAY_LINE_OUT_OF_RANGE,
        output DELAY_LINE_MOVE,
        output DELAY_LINE_DIRECTION,
        output DELAY_LINE_LOAD,
        output EYE_MONITOR_CLEAR_FLAGS
    );

    modport slave (
        output RX_DATA,
        output EYE_MONITOR_EARLY,
        output EYE_MONITOR_LATE,
        output DELAY_LINE_OUT_OF_RANGE,
        input  DELAY_LINE_MOVE,
        input  DELAY_LINE_DIRECTION,
        input  DELAY_LINE_LOAD,
        input  EYE_MONITOR_CLEAR_FLAGS
    );

endinterface

// File: rtl/ddr3_dqsw_sample_vote.sv
// rtl/ddr3_dqsw_sample_vote.sv - per-tap sample voter (pass-through unless DDR3_DQSW_VOTE_EN)
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sample_valid  high for every cycle of the sample window
//   sample_first  first cycle of the window
//   sample_last   last cycle of the window
//   sample_bit    reduced feedback bit for this cycle
//   voted_bit     result, updated on the last window cycle, held until next window
// Macro DDR3_DQSW_VOTE_EN: majority vote over VOTE_SAMPLES cycles; otherwise the
// window is one cycle and the single sample is registered directly.

module ddr3_dqsw_sample_vote
    import ddr3_dqsw_wrlvl_pkg::*;
`ifdef DDR3_DQSW_VOTE_EN
#(
    parameter int VOTE_SAMPLES = 7
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic sample_valid,
    input  logic sample_first,
    input  logic sample_last,
    input  logic sample_bit,
    output logic voted_bit
);

`ifdef DDR3_DQSW_VOTE_EN
    logic [VOTE_CNT_W-1:0] ones_cnt;
    logic [VOTE_CNT_W-1:0] ones_next;

    // Running count of 1s including the current cycle; restarts on the first sample.
    always_comb begin
        ones_next = (sample_first ? '0 : ones_cnt) + VOTE_CNT_W'(sample_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt  <= '0;
            voted_bit <= 1'b0;
        end else if (sample_valid) begin
            ones_cnt <= ones_next;
            if (sample_last) begin
                voted_bit <= (ones_next > VOTE_CNT_W'(VOTE_SAMPLES / 2));
            end
        end
    end
`else
    // Single-cycle window: first and last coincide with valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted_bit <= 1'b0;
        end else if (sample_valid && sample_first && sample_last) begin
            voted_bit <= sample_bit;
        end
    end
`endif

endmodule

// File: rtl/ddr3_dqsw_wrlvl_ctrl.sv
// rtl/ddr3_dqsw_wrlvl_ctrl.sv - DDR3 per-lane DQSW write-leveling sweep controller
//
// Ports:
//   FAB_CLK      fabric clock (same as IOD RX_CLK/TX_CLK)
//   ARST_N       asynchronous active-low reset, aborts any sweep
//   TRAIN_START  1-cycle start pulse, accepted only when not BUSY
//   BUSY         sweep in progress
//   TRAIN_DONE   level, 0->1 transition found
//   TRAIN_ERR    level, sweep exhausted (MAX_TAPS or delay line out of range)
//   TAP_COUNT    taps moved from the load value at the end of the sweep
//   EYE_STATUS   {LATE,EARLY} captured in the final sample window
//   iod          master side of the DQSW training IOD bundle
// Macro DDR3_DQSW_VOTE_EN: sample window of VOTE_SAMPLES cycles with majority vote.

module ddr3_dqsw_wrlvl_ctrl
    import ddr3_dqsw_wrlvl_pkg::*;
#(
    parameter int TAP_W         = 7,
    parameter int MAX_TAPS      = 127,
    parameter int SETTLE_CYCLES = 16,
    parameter int VOTE_SAMPLES  = 7
) (
    input  logic                    FAB_CLK,
    input  logic                    ARST_N,
    input  logic                    TRAIN_START,
    output logic                    BUSY,
    output logic                    TRAIN_DONE,
    output logic                    TRAIN_ERR,
    output logic [TAP_W-1:0]        TAP_COUNT,
    output logic [1:0]              EYE_STATUS,
    ddr3_dqsw_wrlvl_ctrl_if.master  iod
);

    // Elaboration-time parameter guards.
    if (MAX_TAPS < 1 || MAX_TAPS > (1 << TAP_W) - 1) begin : g_chk_max_taps
        $error("MAX_TAPS must be in 1..2**TAP_W-1");
    end
    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > (1 << SETTLE_CNT_W)) begin : g_chk_settle
        $error("SETTLE_CYCLES out of range");
    end
    if (VOTE_SAMPLES < 1 || VOTE_SAMPLES > 15 || (VOTE_SAMPLES % 2) == 0) begin : g_chk_vote
        $error("VOTE_SAMPLES must be odd, 1..15");
    end

    wrlvl_state_e              state;
    wrlvl_state_e              state_next;
    logic [SETTLE_CNT_W-1:0]   settle_cnt;
    logic                      settle_to_sample;  // SETTLE exits to SAMPLE (1) or CLEAR (0)
    logic [TAP_W-1:0]          tap_cnt;
    logic                      seen_zero;
    logic                      tap_at_max;
    logic                      sample_first;
    logic                      sample_last;
    logic                      voted_bit;
    logic                      busy_next;

    // ------------------------------------------------------------------
    // Sample window framing
    // ------------------------------------------------------------------
`ifdef DDR3_DQSW_VOTE_EN
    logic [VOTE_CNT_W-1:0] samp_cnt;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            samp_cnt <= '0;
        end else if (state == S_SAMPLE && !sample_last) begin
            samp_cnt <= samp_cnt + 1'b1;
        end else begin
            samp_cnt <= '0;
        end
    end

    assign sample_first = (samp_cnt == '0);
    assign sample_last  = (samp_cnt == VOTE_CNT_W'(VOTE_SAMPLES - 1));

    ddr3_dqsw_sample_vote #(
        .VOTE_SAMPLES (VOTE_SAMPLES)
    ) u_vote (
`else
    assign sample_first = 1'b1;
    assign sample_last  = 1'b1;

    ddr3_dqsw_sample_vote u_vote (
`endif
        .clk          (FAB_CLK),
        .rst_n        (ARST_N),
        .sample_valid (state == S_SAMPLE),
        .sample_first (sample_first),
        .sample_last  (sample_last),
        .sample_bit   (sample_bit(iod.RX_DATA)),
        .voted_bit    (voted_bit)
    );

    // Saturating compare: tap_cnt can never pass MAX_TAPS, so >= only guards
    // against an unexpected state.
    assign tap_at_max = (tap_cnt >= TAP_W'(MAX_TAPS));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy_next  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (TRAIN_START) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD:   state_next = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = settle_to_sample ? S_SAMPLE : S_CLEAR;
                end
            end
            S_CLEAR:  state_next = S_SETTLE;
            S_SAMPLE: begin
                if (sample_last) begin
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                // A found transition wins over exhaustion in the same evaluation.
                if (voted_bit && seen_zero) begin
                    state_next = S_DONE;
                end else if (tap_at_max || iod.DELAY_LINE_OUT_OF_RANGE) begin
                    state_next = S_FAIL;
                end else begin
                    state_next = S_MOVE;
                end
            end
            S_MOVE:   state_next = S_SETTLE;
            default:  state_next = S_IDLE;
        endcase

        busy_next = !(state_next == S_IDLE || state_next == S_DONE || state_next == S_FAIL);
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs (outputs follow state_next so
    // each pulse lines up with the cycle its state is occupied)
    // ------------------------------------------------------------------
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state                       <= S_IDLE;
            settle_cnt                  <= '0;
            settle_to_sample            <= 1'b0;
            tap_cnt                     <= '0;
            seen_zero                   <= 1'b0;
            BUSY                        <= 1'b0;
            TRAIN_DONE                  <= 1'b0;
            TRAIN_ERR                   <= 1'b0;
            TAP_COUNT                   <= '0;
            EYE_STATUS                  <= 2'b00;
            iod.DELAY_LINE_MOVE         <= 1'b0;
            iod.DELAY_LINE_DIRECTION    <= 1'b0;
            iod.DELAY_LINE_LOAD         <= 1'b0;
            iod.EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
        end else begin
            state <= state_next;

            // Reload on entry, count down, leave at zero: exactly SETTLE_CYCLES cycles.
            if (state_next == S_SETTLE && state != S_SETTLE) begin
                settle_cnt <= SETTLE_CNT_W'(SETTLE_CYCLES - 1);
            end else if (state == S_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            if (state == S_CLEAR) begin
                settle_to_sample <= 1'b1;
            end else if (state == S_LOAD || state == S_MOVE) begin
                settle_to_sample <= 1'b0;
            end

            if (state_next == S_LOAD) begin
                tap_cnt   <= '0;
                seen_zero <= 1'b0;
            end else if (state == S_EVAL) begin
                if (!voted_bit) begin
                    seen_zero <= 1'b1;
                end
                if (state_next == S_MOVE) begin
                    tap_cnt <= tap_cnt + 1'b1;
                end
            end

            if (state_next == S_LOAD) begin
                TAP_COUNT <= '0;
            end else if (state == S_EVAL && (state_next == S_DONE || state_next == S_FAIL)) begin
                TAP_COUNT <= tap_cnt;
            end

            // Captured every window; the value left behind is the final tap's.
            if (state_next == S_LOAD) begin
                EYE_STATUS <= 2'b00;
            end else if (state == S_SAMPLE && sample_last) begin
                EYE_STATUS <= {iod.EYE_MONITOR_LATE, iod.EYE_MONITOR_EARLY};
            end

            BUSY                        <= busy_next;
            TRAIN_DONE                  <= (state_next == S_DONE);
            TRAIN_ERR                   <= (state_next == S_FAIL);
            iod.DELAY_LINE_MOVE         <= (state_next == S_MOVE);
            iod.DELAY_LINE_DIRECTION    <= busy_next;
            iod.DELAY_LINE_LOAD         <= (state_next == S_LOAD);
            iod.EYE_MONITOR_CLEAR_FLAGS <= (state_next == S_CLEAR);
        end
    end

endmodule

// File: tb/tb_ddr3_dqsw_wrlvl_ctrl.sv
// tb/tb_ddr3_dqsw_wrlvl_ctrl.sv - self-checking bench for ddr3_dqsw_wrlvl_ctrl

module tb_ddr3_dqsw_wrlvl_ctrl;

    localparam int TAP_W    = 7;
    localparam int MAX_TAPS = 127;
    localparam int SETTLE   = 16;
    localparam int VOTE     = 7;
    localparam int TIMEOUT  = 20000;

    typedef struct {
        logic       done;
        logic       err;
        int         taps;
        int         moves;
        int         loads;
        logic [1:0] eye;
    } exp_t;

    logic             FAB_CLK = 1'b0;
    logic             ARST_N  = 1'b0;
    logic             TRAIN_START = 1'b0;
    logic             BUSY;
    logic             TRAIN_DONE;
    logic             TRAIN_ERR;
    logic [TAP_W-1:0] TAP_COUNT;
    logic [1:0]       EYE_STATUS;

    ddr3_dqsw_wrlvl_ctrl_if iod ();

    ddr3_dqsw_wrlvl_ctrl #(
        .TAP_W         (TAP_W),
        .MAX_TAPS      (MAX_TAPS),
        .SETTLE_CYCLES (SETTLE),
        .VOTE_SAMPLES  (VOTE)
    ) dut (
        .FAB_CLK     (FAB_CLK),
        .ARST_N      (ARST_N),
        .TRAIN_START (TRAIN_START),
        .BUSY        (BUSY),
        .TRAIN_DONE  (TRAIN_DONE),
        .TRAIN_ERR   (TRAIN_ERR),
        .TAP_COUNT   (TAP_COUNT),
        .EYE_STATUS  (EYE_STATUS),
        .iod         (iod.master)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    // ------------------------------------------------------------------
    // IOD model: tracks tap position from LOAD/MOVE pulses and returns
    // feedback from a per-tap table.
    // ------------------------------------------------------------------
    logic            fb_tbl    [0:MAX_TAPS];
    logic [VOTE-1:0] vote_mask [0:MAX_TAPS];
    bit              use_vote  = 1'b0;
    int              oor_tap   = -1;
    logic [1:0]      zero_code = 2'b00;
    int              tap_pos   = 0;
    int              n_moves   = 0;
    int              n_loads   = 0;
    int              since_clear = 1000;

    always @(negedge FAB_CLK) begin
        int   tp;
        int   idx;
        logic b;
        if (iod.DELAY_LINE_LOAD === 1'b1) begin
            tap_pos = 0;
            n_loads++;
        end
        if (iod.DELAY_LINE_MOVE === 1'b1) begin
            tap_pos++;
            n_moves++;
        end
        if (iod.EYE_MONITOR_CLEAR_FLAGS === 1'b1) since_clear = 0;
        else since_clear++;
        tp  = (tap_pos > MAX_TAPS) ? MAX_TAPS : tap_pos;
        idx = since_clear - SETTLE - 1;
        if (use_vote && idx >= 0 && idx < VOTE) b = vote_mask[tp][idx];
        else b = fb_tbl[tp];
        iod.RX_DATA                 = b ? 2'b11 : zero_code;
        iod.DELAY_LINE_OUT_OF_RANGE = (oor_tap >= 0) && (tap_pos >= oor_tap);
        iod.EYE_MONITOR_EARLY       = tap_pos[0];
        iod.EYE_MONITOR_LATE        = tap_pos[1];
    end

    // Feedback 1 below lead, 0 from lead up to t1-1, 1 from t1 on.
    task automatic set_pattern(input int lead, input int t1);
        for (int i = 0; i <= MAX_TAPS; i++) fb_tbl[i] = (i < lead) || (i >= t1);
    endtask

    // Reference sweep outcome for the current table and out-of-range tap.
    function automatic exp_t predict();
        exp_t e;
        logic seen;
        seen = 1'b0;
        e = '{done: 1'b0, err: 1'b1, taps: MAX_TAPS, moves: MAX_TAPS, loads: 1, eye: 2'b11};
        for (int t = 0; t <= MAX_TAPS; t++) begin
            if (fb_tbl[t] && seen) begin
                e = '{done: 1'b1, err: 1'b0, taps: t, moves: t, loads: 1, eye: {t[1], t[0]}};
                return e;
            end
            if (!fb_tbl[t]) seen = 1'b1;
            if (t == MAX_TAPS || (oor_tap >= 0 && t >= oor_tap)) begin
                e = '{done: 1'b0, err: 1'b1, taps: t, moves: t, loads: 1, eye: {t[1], t[0]}};
                return e;
            end
        end
        return e;
    endfunction

    // Start one sweep, optionally re-pulse TRAIN_START at cycle extra_cyc, and
    // compare the result against the head of the scoreboard.
    task automatic run_sweep(input string name, input int extra_cyc);
        exp_t e;
        int   cyc;
        @(negedge FAB_CLK);
        n_moves = 0;
        n_loads = 0;
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        n_cmp++;
        if (BUSY !== 1'b1 || iod.DELAY_LINE_LOAD !== 1'b1 || iod.DELAY_LINE_DIRECTION !== 1'b1) begin
            n_err++;
            $display("FAIL %s start: busy/load/dir=%b%b%b required 111", name, BUSY,
                     iod.DELAY_LINE_LOAD, iod.DELAY_LINE_DIRECTION);
        end
        n_cmp++;
        if (TRAIN_DONE !== 1'b0 || TRAIN_ERR !== 1'b0) begin
            n_err++;
            $display("FAIL %s flags_cleared: done/err=%b%b required 00", name, TRAIN_DONE, TRAIN_ERR);
        end
        cyc = 0;
        while (BUSY === 1'b1 && cyc < TIMEOUT) begin
            @(negedge FAB_CLK);
            cyc++;
            TRAIN_START = (cyc == extra_cyc);
        end
        TRAIN_START = 1'b0;
        n_cmp++;
        if (cyc >= TIMEOUT) begin
            n_err++;
            $display("FAIL %s timeout: busy=%b after %0d cycles required 0", name, BUSY, cyc);
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s scoreboard: empty required 1 entry", name);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (TRAIN_DONE !== e.done || TRAIN_ERR !== e.err) begin
            n_err++;
            $display("FAIL %s result: done/err=%b%b required %b%b", name, TRAIN_DONE, TRAIN_ERR, e.done, e.err);
        end
        n_cmp++;
        if (TAP_COUNT !== TAP_W'(e.taps)) begin
            n_err++;
            $display("FAIL %s tap_count: got %0d required %0d", name, TAP_COUNT, e.taps);
        end
        n_cmp++;
        if (n_moves != e.moves) begin
            n_err++;
            $display("FAIL %s moves: got %0d required %0d", name, n_moves, e.moves);
        end
        n_cmp++;
        if (n_loads != e.loads) begin
            n_err++;
            $display("FAIL %s loads: got %0d required %0d", name, n_loads, e.loads);
        end
        n_cmp++;
        if (EYE_STATUS !== e.eye) begin
            n_err++;
            $display("FAIL %s eye_status: got %b required %b", name, EYE_STATUS, e.eye);
        end
        n_cmp++;
        if (iod.DELAY_LINE_DIRECTION !== 1'b0) begin
            n_err++;
            $display("FAIL %s dir_idle: got %b required 0", name, iod.DELAY_LINE_DIRECTION);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({BUSY, TRAIN_DONE, TRAIN_ERR} !== 3'b000) begin
            n_err++;
            $display("FAIL %s flags: busy/done/err=%b%b%b required 000", name, BUSY, TRAIN_DONE, TRAIN_ERR);
        end
        n_cmp++;
        if (TAP_COUNT !== '0 || EYE_STATUS !== 2'b00) begin
            n_err++;
            $display("FAIL %s status: tap=%0d eye=%b required 0 00", name, TAP_COUNT, EYE_STATUS);
        end
        n_cmp++;
        if ({iod.DELAY_LINE_MOVE, iod.DELAY_LINE_DIRECTION, iod.DELAY_LINE_LOAD,
             iod.EYE_MONITOR_CLEAR_FLAGS} !== 4'b0000) begin
            n_err++;
            $display("FAIL %s iod_ctrl: move/dir/load/clear=%b%b%b%b required 0000", name,
                     iod.DELAY_LINE_MOVE, iod.DELAY_LINE_DIRECTION, iod.DELAY_LINE_LOAD,
                     iod.EYE_MONITOR_CLEAR_FLAGS);
        end
    endtask

    task automatic test_reset();
        ARST_N = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        check_all_zero("reset");
        ARST_N = 1'b1;
        @(negedge FAB_CLK);
    endtask

    task automatic test_transition();
        set_pattern(0, 10);
        oor_tap = -1;
        zero_code = 2'b00;
        sb.push_back('{done: 1'b1, err: 1'b0, taps: 10, moves: 10, loads: 1, eye: 2'b10});
        run_sweep("transition_at_10", -1);
    endtask

    task automatic test_leading_ones();
        set_pattern(4, 8);
        zero_code = 2'b01;  // split capture must read as 0
        sb.push_back('{done: 1'b1, err: 1'b0, taps: 8, moves: 8, loads: 1, eye: 2'b00});
        run_sweep("leading_ones", -1);
    endtask

    task automatic test_all_zero();
        set_pattern(0, MAX_TAPS + 1);
        zero_code = 2'b10;
        sb.push_back('{done: 1'b0, err: 1'b1, taps: 127, moves: 127, loads: 1, eye: 2'b11});
        run_sweep("all_zero_max_taps", -1);
        zero_code = 2'b00;
    endtask

    task automatic test_out_of_range();
        set_pattern(0, MAX_TAPS + 1);
        oor_tap = 5;
        sb.push_back('{done: 1'b0, err: 1'b1, taps: 5, moves: 5, loads: 1, eye: 2'b01});
        run_sweep("oor_fail", -1);
        set_pattern(0, 5);
        sb.push_back('{done: 1'b1, err: 1'b0, taps: 5, moves: 5, loads: 1, eye: 2'b01});
        run_sweep("oor_done_wins", -1);
        oor_tap = -1;
    endtask

    task automatic test_async_abort();
        int cyc;
        set_pattern(0, MAX_TAPS + 1);
        @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        cyc = 0;
        while (n_moves < 20 && cyc < TIMEOUT) begin
            @(negedge FAB_CLK);
            cyc++;
        end
        repeat (5) @(negedge FAB_CLK);
        n_cmp++;
        if (BUSY !== 1'b1 || n_moves != 20) begin
            n_err++;
            $display("FAIL abort_precondition: busy=%b moves=%0d required 1 20", BUSY, n_moves);
        end
        #2 ARST_N = 1'b0;
        #1 check_all_zero("async_abort");
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        set_pattern(0, 3);
        sb.push_back('{done: 1'b1, err: 1'b0, taps: 3, moves: 3, loads: 1, eye: 2'b11});
        run_sweep("restart_after_abort", -1);
    endtask

    task automatic test_start_while_busy();
        set_pattern(0, 6);
        sb.push_back('{done: 1'b1, err: 1'b0, taps: 6, moves: 6, loads: 1, eye: 2'b10});
        run_sweep("start_while_busy", 100);
    endtask

    task automatic test_back_to_back();
        int t1;
        int lead;
        for (int k = 0; k < 4; k++) begin
            t1   = $urandom_range(2, 24);
            lead = $urandom_range(0, t1 - 1);
            set_pattern(lead, t1);
            oor_tap = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 26) : -1;
            sb.push_back(predict());
            run_sweep($sformatf("back_to_back_%0d", k), -1);
        end
        oor_tap = -1;
    endtask

`ifdef DDR3_DQSW_VOTE_EN
    task automatic test_vote();
        set_pattern(0, MAX_TAPS + 1);
        use_vote = 1'b1;
        vote_mask[0] = 7'b1100001;  // 3 of 7 (first sample 1) -> 0
        vote_mask[1] = 7'b0011110;  // 4 of 7 (first sample 0) -> 1
        sb.push_back('{done: 1'b1, err: 1'b0, taps: 1, moves: 1, loads: 1, eye: 2'b01});
        run_sweep("vote_majority", -1);
        use_vote = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i <= MAX_TAPS; i++) vote_mask[i] = '0;
        set_pattern(0, MAX_TAPS + 1);
        iod.RX_DATA                 = 2'b00;
        iod.EYE_MONITOR_EARLY       = 1'b0;
        iod.EYE_MONITOR_LATE        = 1'b0;
        iod.DELAY_LINE_OUT_OF_RANGE = 1'b0;
        test_reset();
        test_transition();
        test_leading_ones();
        test_all_zero();
        test_out_of_range();
        test_async_abort();
        test_start_while_busy();
        test_back_to_back();
`ifdef DDR3_DQSW_VOTE_EN
        test_vote();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
